palm_locator: RTL and testbench

- Upstream stage of finger_identification.
- Consumes the binarised hand image as a raster pixel stream and finds the palm row: the row, within a search window, whose longest horizontal run of 1-pixels is widest.
- Publishes that run's start column, end column, width and a derived finger width, then raises flag, which starts finger box evaluation downstream.
- While flag is low, the downstream block captures the same pixel stream into its frame store.

---
 rtl/palm_pkg.sv | 32 +++
 rtl/palm_run_tracker.sv | 167 ++++++++++++++++
 rtl/palm_locator.sv | 183 ++++++++++++++++++
 tb/tb_palm_locator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palm_pkg.sv
//------------------------------------------------------------------------------
// Module   : palm_pkg
// Purpose  : Shared image geometry, coordinate type and FSM states for the
//            palm locator and the downstream finger_identification block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package palm_pkg;

  localparam int IMAGE_WIDTH  = 384;
  localparam int IMAGE_HEIGHT = 216;
  localparam int COORD_W      = 9;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Saturating add; run lengths never exceed one image row.
  function automatic coord_t sat_add(input coord_t a, input coord_t b, input coord_t lim);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[COORD_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/palm_run_tracker.sv
//------------------------------------------------------------------------------
// Module   : palm_run_tracker
// Purpose  : Per-row longest run of 1-pixels; strobes row_done with the row
//            best. PALM_LOCATOR_HOLE_FILL_EN bridges single-pixel gaps.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module palm_run_tracker
  import palm_pkg::*;
#(
  parameter int IMAGE_WIDTH = palm_pkg::IMAGE_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   pixel,
  input  logic   valid,
  input  coord_t col,
  input  logic   row_first,
  input  logic   row_last,
  output coord_t best_start,
  output coord_t best_end,
  output coord_t best_len,
  output logic   row_done
);

  localparam coord_t c_one     = coord_t'(1);
  localparam coord_t c_two     = coord_t'(2);
  localparam coord_t c_run_max = coord_t'(IMAGE_WIDTH);

  logic   r_in_run;
  logic   r_pending;
  coord_t r_run_start;
  coord_t r_run_len;
  coord_t r_best_start;
  coord_t r_best_end;
  coord_t r_best_len;

  logic   w_base_in_run;
  logic   w_base_pending;
  coord_t w_base_start;
  coord_t w_base_end;
  coord_t w_base_len;
  logic   w_nxt_in_run;
  logic   w_nxt_pending;
  coord_t w_nxt_start;
  coord_t w_nxt_len;
  logic   w_close;
  coord_t w_nxt_best_start;
  coord_t w_nxt_best_end;
  coord_t w_nxt_best_len;

  always_comb begin
    w_base_in_run  = row_first ? 1'b0 : r_in_run;
    w_base_pending = row_first ? 1'b0 : r_pending;
    w_base_start   = row_first ? '0 : r_best_start;
    w_base_end     = row_first ? '0 : r_best_end;
    w_base_len     = row_first ? '0 : r_best_len;
    w_nxt_in_run   = w_base_in_run;
    w_nxt_pending  = w_base_pending;
    w_nxt_start    = r_run_start;
    w_nxt_len      = r_run_len;
    w_close        = 1'b0;
    if (pixel) begin
      if (w_base_in_run) begin
        // A pending gap pixel is absorbed into the run together with this one.
        w_nxt_len = sat_add(r_run_len, w_base_pending ? c_two : c_one, c_run_max);
      end else begin
        w_nxt_start = col;
        w_nxt_len   = c_one;
      end
      w_nxt_in_run  = 1'b1;
      w_nxt_pending = 1'b0;
    end else if (w_base_in_run) begin
`ifdef PALM_LOCATOR_HOLE_FILL_EN
      if (w_base_pending) begin
        w_close       = 1'b1;
        w_nxt_in_run  = 1'b0;
        w_nxt_pending = 1'b0;
      end else begin
        w_nxt_pending = 1'b1;
      end
`else
      w_close      = 1'b1;
      w_nxt_in_run = 1'b0;
`endif
    end
    if (row_last && w_nxt_in_run) begin
      w_close       = 1'b1;
      w_nxt_in_run  = 1'b0;
      w_nxt_pending = 1'b0;
    end
    w_nxt_best_start = w_base_start;
    w_nxt_best_end   = w_base_end;
    w_nxt_best_len   = w_base_len;
    if (w_close && (w_nxt_len > w_base_len)) begin
      w_nxt_best_start = w_nxt_start;
      w_nxt_best_end   = w_nxt_start + w_nxt_len - c_one;
      w_nxt_best_len   = w_nxt_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_run     <= 1'b0;
      r_pending    <= 1'b0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_end   <= '0;
      r_best_len   <= '0;
    end else if (valid) begin
      r_in_run     <= w_nxt_in_run;
      r_pending    <= w_nxt_pending;
      r_run_start  <= w_nxt_start;
      r_run_len    <= w_nxt_len;
      r_best_start <= w_nxt_best_start;
      r_best_end   <= w_nxt_best_end;
      r_best_len   <= w_nxt_best_len;
    end else if (clr) begin
      r_in_run     <= 1'b0;
      r_pending    <= 1'b0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_end   <= '0;
      r_best_len   <= '0;
    end
  end

`ifdef PALM_LOCATOR_HOLE_FILL_EN
  coord_t r_out_start;
  coord_t r_out_end;
  coord_t r_out_len;
  logic   r_out_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_start <= '0;
      r_out_end   <= '0;
      r_out_len   <= '0;
      r_out_done  <= 1'b0;
    end else begin
      r_out_done <= valid & row_last;
      if (valid && row_last) begin
        r_out_start <= w_nxt_best_start;
        r_out_end   <= w_nxt_best_end;
        r_out_len   <= w_nxt_best_len;
      end
    end
  end

  assign best_start = r_out_start;
  assign best_end   = r_out_end;
  assign best_len   = r_out_len;
  assign row_done   = r_out_done;
`else
  assign best_start = w_nxt_best_start;
  assign best_end   = w_nxt_best_end;
  assign best_len   = w_nxt_best_len;
  assign row_done   = valid & row_last;
`endif

endmodule

`default_nettype wire

// File: rtl/palm_locator.sv
//------------------------------------------------------------------------------
// Module   : palm_locator
// Purpose  : Finds the windowed row with the widest run of hand pixels and
//            publishes it with flag. Option macro: PALM_LOCATOR_HOLE_FILL_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module palm_locator
  import palm_pkg::*;
#(
  parameter int IMAGE_WIDTH  = palm_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = palm_pkg::IMAGE_HEIGHT,
  parameter int ROW_MIN      = 90,
  parameter int ROW_MAX      = 200,
  parameter int MIN_RUN      = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sof,
  input  logic               pixel_valid,
  input  logic               object_image,
  output logic [COORD_W-1:0] palm_width,
  output logic [COORD_W-1:0] start_of_palm_c,
  output logic [COORD_W-1:0] end_of_palm_c,
  output logic [COORD_W-1:0] finger_width,
  output logic [COORD_W-1:0] palm_row,
  output logic               flag
);

  localparam coord_t c_one      = coord_t'(1);
  localparam coord_t c_col_last = coord_t'(IMAGE_WIDTH - 1);
  localparam coord_t c_row_last = coord_t'(IMAGE_HEIGHT - 1);
  localparam coord_t c_row_min  = coord_t'(ROW_MIN);
  localparam coord_t c_row_max  = coord_t'(ROW_MAX);
  localparam coord_t c_min_run  = coord_t'(MIN_RUN);

  state_t r_state;
  coord_t r_col;
  coord_t r_row;
  coord_t r_fb_start;
  coord_t r_fb_end;
  coord_t r_fb_len;
  coord_t r_fb_row;

  coord_t w_col;
  coord_t w_row;
  logic   w_take;
  logic   w_hold;
  logic   w_row_last;
  logic   w_frame_last;
  coord_t w_rb_start;
  coord_t w_rb_end;
  coord_t w_rb_len;
  logic   w_rb_done;
  coord_t w_eval_row;
  logic   w_eval_frame_end;
  logic   w_cand;

  // A pixel arriving with sof is pixel (0,0) of the new frame.
  assign w_col        = sof ? '0 : r_col;
  assign w_row        = sof ? '0 : r_row;
  assign w_take       = pixel_valid & (sof | ((r_state == SCAN) & ~w_hold));
  assign w_row_last   = (w_col == c_col_last);
  assign w_frame_last = w_row_last & (w_row == c_row_last);

  palm_run_tracker #(
    .IMAGE_WIDTH (IMAGE_WIDTH)
  ) u_run_tracker (
    .clk        (clk),
    .rst        (rst),
    .clr        (sof),
    .pixel      (object_image),
    .valid      (w_take),
    .col        (w_col),
    .row_first  (w_col == '0),
    .row_last   (w_row_last),
    .best_start (w_rb_start),
    .best_end   (w_rb_end),
    .best_len   (w_rb_len),
    .row_done   (w_rb_done)
  );

`ifdef PALM_LOCATOR_HOLE_FILL_EN
  // Tracker results trail the pixel by one cycle; carry row context alongside.
  coord_t r_eval_row;
  logic   r_eval_frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eval_row       <= '0;
      r_eval_frame_end <= 1'b0;
    end else begin
      r_eval_row       <= w_row;
      r_eval_frame_end <= w_take & w_frame_last;
    end
  end

  assign w_eval_row       = r_eval_row;
  assign w_eval_frame_end = r_eval_frame_end;
  assign w_hold           = r_eval_frame_end;
`else
  assign w_eval_row       = w_row;
  assign w_eval_frame_end = w_take & w_frame_last;
  assign w_hold           = 1'b0;
`endif

  // Strict compare: on equal widths the earlier row is kept.
  assign w_cand = w_rb_done
                & (w_eval_row >= c_row_min) & (w_eval_row <= c_row_max)
                & (w_rb_len >= c_min_run) & (w_rb_len > r_fb_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_take) begin
      if (w_row_last) begin
        r_col <= '0;
        r_row <= (w_row == c_row_last) ? '0 : w_row + c_one;
      end else begin
        r_col <= w_col + c_one;
        r_row <= w_row;
      end
    end else if (sof) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= SCAN;
      r_fb_start      <= '0;
      r_fb_end        <= '0;
      r_fb_len        <= '0;
      r_fb_row        <= '0;
      palm_width      <= '0;
      start_of_palm_c <= '0;
      end_of_palm_c   <= '0;
      finger_width    <= '0;
      palm_row        <= '0;
      flag            <= 1'b0;
    end else if (sof) begin
      r_state    <= SCAN;
      r_fb_start <= '0;
      r_fb_end   <= '0;
      r_fb_len   <= '0;
      r_fb_row   <= '0;
      flag       <= 1'b0;
    end else begin
      if (w_cand) begin
        r_fb_start <= w_rb_start;
        r_fb_end   <= w_rb_end;
        r_fb_len   <= w_rb_len;
        r_fb_row   <= w_eval_row;
      end
      case (r_state)
        SCAN: begin
          if (w_eval_frame_end) r_state <= RESOLVE;
        end
        RESOLVE: begin
          palm_width      <= r_fb_len;
          start_of_palm_c <= r_fb_start;
          end_of_palm_c   <= r_fb_end;
          finger_width    <= r_fb_len >> 2;
          palm_row        <= r_fb_row;
          flag            <= 1'b1;
          r_state         <= DONE;
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= SCAN;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_palm_locator.sv
//------------------------------------------------------------------------------
// Module   : tb_palm_locator
// Purpose  : Directed self-checking bench for palm_locator on a 16x8 image.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_palm_locator;

  localparam int W = 16;
  localparam int H = 8;
`ifdef PALM_LOCATOR_HOLE_FILL_EN
  localparam int c_lat = 3;
`else
  localparam int c_lat = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sof = 1'b0;
  logic       pixel_valid = 1'b0;
  logic       object_image = 1'b0;
  logic [8:0] palm_width;
  logic [8:0] start_of_palm_c;
  logic [8:0] end_of_palm_c;
  logic [8:0] finger_width;
  logic [8:0] palm_row;
  logic       flag;

  int          total = 0;
  int          bad = 0;
  logic [15:0] img [H];
  logic [45:0] obs;
  logic [45:0] exp_v;
  int          cyc;

  always #5 clk = ~clk;

  palm_locator #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .ROW_MIN      (2),
    .ROW_MAX      (6),
    .MIN_RUN      (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sof             (sof),
    .pixel_valid     (pixel_valid),
    .object_image    (object_image),
    .palm_width      (palm_width),
    .start_of_palm_c (start_of_palm_c),
    .end_of_palm_c   (end_of_palm_c),
    .finger_width    (finger_width),
    .palm_row        (palm_row),
    .flag            (flag)
  );

  assign obs = {flag, palm_width, start_of_palm_c, end_of_palm_c, finger_width, palm_row};

  task automatic clear_img();
    for (int i = 0; i < H; i++) img[i] = 16'h0000;
  endtask

  task automatic pulse_sof();
    @(negedge clk);
    sof = 1'b1;
    pixel_valid = 1'b0;
    @(negedge clk);
    sof = 1'b0;
  endtask

  // Streams img; cyc = cycles from the last pixel until flag is seen high.
  task automatic run_frame(input bit with_sof, input bit bubbles, output int n_cyc);
    int n;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (bubbles && (((r * W + c) % 5) == 3)) begin
          @(negedge clk);
          pixel_valid = 1'b0;
          sof = 1'b0;
        end
        @(negedge clk);
        pixel_valid  = 1'b1;
        object_image = img[r][c];
        sof          = with_sof && (r == 0) && (c == 0);
      end
    end
    @(negedge clk);
    pixel_valid  = 1'b0;
    object_image = 1'b0;
    sof          = 1'b0;
    n = 0;
    while (flag !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cyc = n + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== 46'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 46'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_run();
    clear_img();
    img[4] = 16'h1FE0;
    pulse_sof();
    run_frame(1'b0, 1'b0, cyc);
    total++;
    if (cyc !== c_lat) begin
      bad++;
      $display("FAIL single_latency: got %0d expected %0d", cyc, c_lat);
    end
    exp_v = {1'b1, 9'd8, 9'd5, 9'd12, 9'd2, 9'd4};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL single_result: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_sof_in_done();
    pulse_sof();
    exp_v = {1'b0, 9'd8, 9'd5, 9'd12, 9'd2, 9'd4};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL sof_in_done: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_window_tie();
    clear_img();
    img[1] = 16'h03FF;
    img[3] = 16'h00FC;
    img[5] = 16'h3F00;
    pulse_sof();
    run_frame(1'b0, 1'b1, cyc);
    total++;
    if (cyc !== c_lat) begin
      bad++;
      $display("FAIL tie_latency: got %0d expected %0d", cyc, c_lat);
    end
    exp_v = {1'b1, 9'd6, 9'd2, 9'd7, 9'd1, 9'd3};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL tie_result: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_row_end();
    clear_img();
    img[4] = 16'hFFC7;
    pulse_sof();
    run_frame(1'b0, 1'b0, cyc);
    total++;
    if (cyc !== c_lat) begin
      bad++;
      $display("FAIL row_end_latency: got %0d expected %0d", cyc, c_lat);
    end
    exp_v = {1'b1, 9'd10, 9'd6, 9'd15, 9'd2, 9'd4};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL row_end_result: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_no_candidate();
    for (int i = 0; i < H; i++) img[i] = 16'h3333;
    pulse_sof();
    run_frame(1'b0, 1'b0, cyc);
    total++;
    if (cyc !== c_lat) begin
      bad++;
      $display("FAIL none_latency: got %0d expected %0d", cyc, c_lat);
    end
    exp_v = {1'b1, 45'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL none_result: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_abort_restart();
    clear_img();
    img[2] = 16'hFFFF;
    pulse_sof();
    for (int p = 0; p < 3 * W + 6; p++) begin
      @(negedge clk);
      pixel_valid  = 1'b1;
      object_image = img[p / W][p % W];
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    exp_v = {1'b0, 45'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL abort_midframe: got %h expected %h", obs, exp_v);
    end
    clear_img();
    img[4] = 16'h1FE0;
    run_frame(1'b1, 1'b0, cyc);
    total++;
    if (cyc !== c_lat) begin
      bad++;
      $display("FAIL restart_latency: got %0d expected %0d", cyc, c_lat);
    end
    exp_v = {1'b1, 9'd8, 9'd5, 9'd12, 9'd2, 9'd4};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL restart_result: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_hole_fill();
    clear_img();
    img[4] = 16'h1DE0;
    pulse_sof();
    run_frame(1'b0, 1'b0, cyc);
    total++;
    if (cyc !== c_lat) begin
      bad++;
      $display("FAIL hole_latency: got %0d expected %0d", cyc, c_lat);
    end
`ifdef PALM_LOCATOR_HOLE_FILL_EN
    exp_v = {1'b1, 9'd8, 9'd5, 9'd12, 9'd2, 9'd4};
`else
    exp_v = {1'b1, 9'd4, 9'd5, 9'd8, 9'd1, 9'd4};
`endif
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL hole_result: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    clear_img();
    pulse_sof();
    for (int p = 0; p < 2 * W + 3; p++) begin
      @(negedge clk);
      pixel_valid  = 1'b1;
      object_image = 1'b1;
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== 46'd0) begin
      bad++;
      $display("FAIL async_reset: got %h expected %h", obs, 46'd0);
    end
    @(negedge clk);
    pixel_valid  = 1'b0;
    object_image = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_img();
    img[6] = 16'h0FF0;
    img[2] = 16'h00F8;
    run_frame(1'b0, 1'b0, cyc);
    total++;
    if (cyc !== c_lat) begin
      bad++;
      $display("FAIL b2b_latency: got %0d expected %0d", cyc, c_lat);
    end
    exp_v = {1'b1, 9'd8, 9'd4, 9'd11, 9'd2, 9'd6};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL b2b_result: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_sof_in_done();
    test_window_tie();
    test_row_end();
    test_no_candidate();
    test_abort_restart();
    test_hole_fill();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
